// File: rtl/instr_stim_sequencer.sv
// rtl/instr_stim_sequencer.sv - programmable instruction/memdatain stimulus sequencer
// Holds a loaded program and presents it to the core one entry at a time.
module instr_stim_sequencer #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 16,
  parameter int               HOLD_CYCLES = 1,
  parameter logic [WIDTH-1:0] NOP_INSTR   = 32'hE1A00000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [WIDTH-1:0]         load_instr,
  input  logic [WIDTH-1:0]         load_data,
  input  logic [$clog2(DEPTH):0]   prog_len,
  input  logic                     start,
  input  logic                     loop_en,
  input  logic                     stop,
  output logic [WIDTH-1:0]         instruction,
  output logic [WIDTH-1:0]         memdatain,
  output logic                     valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic [15:0]              issued_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] data_mem  [DEPTH];

  state_t           state_q, state_d;
  logic [WIDTH-1:0] instruction_q, instruction_d;
  logic [WIDTH-1:0] memdatain_q, memdatain_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AW-1:0]    step_idx_q, step_idx_d;
  logic [15:0]      issued_count_q, issued_count_d;
  logic [AW:0]      len_q, len_d;
  logic             loop_q, loop_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic             last_hold;
  logic [AW:0]      step_ext;

  // Buffer has no reset; writes are accepted in every state, including during rst.
  always_ff @(posedge clk) begin
    if (load_en) begin
      instr_mem[load_addr] <= load_instr;
      data_mem[load_addr]  <= load_data;
    end
  end

  always_comb begin
    state_d        = state_q;
    instruction_d  = instruction_q;
    memdatain_d    = memdatain_q;
    valid_d        = valid_q;
    done_d         = 1'b0;
    step_idx_d     = step_idx_q;
    issued_count_d = issued_count_q;
    len_d          = len_q;
    loop_d         = loop_q;
    hold_cnt_d     = hold_cnt_q;
    last_hold      = (hold_cnt_q == HOLD_LAST);
    step_ext       = {1'b0, step_idx_q} + (AW+1)'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          step_idx_d     = '0;
          issued_count_d = '0;
          hold_cnt_d     = '0;
          loop_d         = loop_en;
          len_d          = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
          if (prog_len == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d       = S_RUN;
            valid_d       = 1'b1;
            instruction_d = instr_mem[0];
            memdatain_d   = data_mem[0];
          end
        end
      end
      S_RUN: begin
        hold_cnt_d = last_hold ? '0 : hold_cnt_q + HW'(1);
        if (last_hold && issued_count_q != 16'hFFFF) begin
          issued_count_d = issued_count_q + 16'd1;
        end
        // stop outranks the boundary decision, but the finishing entry still counts.
        if (stop) begin
          state_d       = S_IDLE;
          valid_d       = 1'b0;
          instruction_d = NOP_INSTR;
          memdatain_d   = '0;
        end else if (last_hold) begin
          if (step_ext < len_q || loop_q) begin
            step_idx_d    = (step_ext < len_q) ? step_ext[AW-1:0] : '0;
            instruction_d = instr_mem[step_idx_d];
            memdatain_d   = data_mem[step_idx_d];
          end else begin
            state_d       = S_DONE;
            done_d        = 1'b1;
            valid_d       = 1'b0;
            instruction_d = NOP_INSTR;
            memdatain_d   = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      instruction_q  <= NOP_INSTR;
      memdatain_q    <= '0;
      valid_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      step_idx_q     <= '0;
      issued_count_q <= '0;
      len_q          <= '0;
      loop_q         <= 1'b0;
      hold_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      instruction_q  <= instruction_d;
      memdatain_q    <= memdatain_d;
      valid_q        <= valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      step_idx_q     <= step_idx_d;
      issued_count_q <= issued_count_d;
      len_q          <= len_d;
      loop_q         <= loop_d;
      hold_cnt_q     <= hold_cnt_d;
    end
  end

  assign instruction  = instruction_q;
  assign memdatain    = memdatain_q;
  assign valid        = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign step_idx     = step_idx_q;
  assign issued_count = issued_count_q;

endmodule

// File: tb/tb_instr_stim_sequencer.sv
// tb/tb_instr_stim_sequencer.sv - bench for instr_stim_sequencer (HOLD 1 and HOLD 2 instances)
// Both instances share stimulus; each is compared every cycle against a program-position model.
module tb_instr_stim_sequencer;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk, rst, load_en, start, loop_en, stop;
  logic [3:0]  load_addr;
  logic [31:0] load_instr, load_data;
  logic [4:0]  prog_len;

  logic [31:0] w1_instr, w1_data, w2_instr, w2_data;
  logic        w1_valid, w1_busy, w1_done, w2_valid, w2_busy, w2_done;
  logic [3:0]  w1_step, w2_step;
  logic [15:0] w1_issued, w2_issued;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  instr_stim_sequencer #(.WIDTH(32), .DEPTH(16), .HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_instr(load_instr), .load_data(load_data), .prog_len(prog_len),
    .start(start), .loop_en(loop_en), .stop(stop),
    .instruction(w1_instr), .memdatain(w1_data), .valid(w1_valid), .busy(w1_busy),
    .done(w1_done), .step_idx(w1_step), .issued_count(w1_issued)
  );

  instr_stim_sequencer #(.WIDTH(32), .DEPTH(16), .HOLD_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_instr(load_instr), .load_data(load_data), .prog_len(prog_len),
    .start(start), .loop_en(loop_en), .stop(stop),
    .instruction(w2_instr), .memdatain(w2_data), .valid(w2_valid), .busy(w2_busy),
    .done(w2_done), .step_idx(w2_step), .issued_count(w2_issued)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: position in the program is cycles-since-start divided by hold.
  int          m_hold [2] = '{1, 2};
  bit          m_run [2], m_dn [2], m_loop [2];
  int          m_t [2], m_len [2];
  logic [31:0] e_instr [2], e_data [2];
  bit          e_valid [2], e_busy [2], e_done [2];
  int          e_step [2], e_issued [2];
  logic [31:0] mb_i [16], mb_d [16];

  task automatic model_step(input int m);
    int k;
    bit bnd;
    if (rst) begin
      m_run[m] = 0; m_dn[m] = 0; e_instr[m] = NOP; e_data[m] = 0; e_valid[m] = 0;
      e_busy[m] = 0; e_done[m] = 0; e_step[m] = 0; e_issued[m] = 0;
      return;
    end
    e_done[m] = 0;
    if (m_dn[m]) begin
      m_dn[m] = 0;
    end else if (m_run[m]) begin
      bnd = (m_t[m] % m_hold[m]) == m_hold[m] - 1;
      k = m_t[m] / m_hold[m];
      m_t[m]++;
      if (bnd && e_issued[m] < 65535) e_issued[m]++;
      if (stop) begin
        m_run[m] = 0; e_valid[m] = 0; e_busy[m] = 0; e_instr[m] = NOP; e_data[m] = 0;
      end else if (bnd) begin
        if (k + 1 < m_len[m] || m_loop[m]) begin
          e_step[m] = (k + 1) % m_len[m];
          e_instr[m] = mb_i[e_step[m]];
          e_data[m] = mb_d[e_step[m]];
        end else begin
          m_run[m] = 0; m_dn[m] = 1; e_done[m] = 1; e_valid[m] = 0; e_busy[m] = 0;
          e_instr[m] = NOP; e_data[m] = 0;
        end
      end
    end else if (start) begin
      e_issued[m] = 0; e_step[m] = 0; m_t[m] = 0; m_loop[m] = loop_en;
      m_len[m] = (int'(prog_len) > 16) ? 16 : int'(prog_len);
      if (m_len[m] == 0) begin
        m_dn[m] = 1; e_done[m] = 1;
      end else begin
        m_run[m] = 1; e_valid[m] = 1; e_busy[m] = 1; e_instr[m] = mb_i[0]; e_data[m] = mb_d[0];
      end
    end
  endtask

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) model_step(m);
    if (load_en) begin
      mb_i[load_addr] = load_instr;
      mb_d[load_addr] = load_data;
    end
  end

  task automatic cmp_dut(input int m, input logic [31:0] ins, input logic [31:0] dat,
                         input logic vld, input logic bsy, input logic dn,
                         input logic [3:0] stp, input logic [15:0] iss);
    string p;
    p = $sformatf("d%0d_", m + 1);
    chk({p, "instr"}, 64'(ins), 64'(e_instr[m]));
    if (e_valid[m]) chk({p, "data"}, 64'(dat), 64'(e_data[m]));
    chk({p, "valid"}, 64'(vld), 64'(e_valid[m]));
    chk({p, "busy"}, 64'(bsy), 64'(e_busy[m]));
    chk({p, "done"}, 64'(dn), 64'(e_done[m]));
    chk({p, "step"}, 64'(stp), 64'(e_step[m]));
    chk({p, "issued"}, 64'(iss), 64'(e_issued[m]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut(0, w1_instr, w1_data, w1_valid, w1_busy, w1_done, w1_step, w1_issued);
      cmp_dut(1, w2_instr, w2_data, w2_valid, w2_busy, w2_done, w2_step, w2_issued);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int a, input logic [31:0] i, input logic [31:0] d);
    load_en = 1; load_addr = 4'(a); load_instr = i; load_data = d;
    cyc();
    load_en = 0;
  endtask

  task automatic go(input int pl, input bit lp);
    start = 1; prog_len = 5'(pl); loop_en = lp;
    cyc();
    start = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!w1_busy && !w2_busy && !w1_done && !w2_done) begin
        cyc();
        return;
      end
      cyc();
    end
    chk("idle_timeout", 64'(1), 64'(0));
  endtask

  logic [31:0] s1 [5] = '{32'hE3E00017, 32'hE0812000, 32'hE0823081, 32'hE3A0F000, 32'hEA000004};

  initial begin
    rst = 1; load_en = 0; load_addr = 0; load_instr = 0; load_data = 0;
    prog_len = 0; start = 0; loop_en = 0; stop = 0;
    cyc(); cyc();
    chk_en = 1;
    chk("rst_instr", 64'(w1_instr), 64'(NOP));
    chk("rst_data", 64'(w1_data), 64'(0));
    chk("rst_valid", 64'(w1_valid), 64'(0));
    chk("rst_busy", 64'(w1_busy), 64'(0));
    chk("rst_issued", 64'(w1_issued), 64'(0));
    rst = 0;
    for (int i = 0; i < 16; i++) load(i, $urandom, $urandom);

    // five-entry program, no loop
    for (int i = 0; i < 5; i++) load(i, s1[i], 32'h0);
    go(5, 0);
    for (int i = 0; i < 5; i++) begin
      chk("s1_instr", 64'(w1_instr), 64'(s1[i]));
      chk("s1_valid", 64'(w1_valid), 64'(1));
      cyc();
    end
    chk("s1_done", 64'(w1_done), 64'(1));
    chk("s1_issued", 64'(w1_issued), 64'(5));
    chk("s1_nop", 64'(w1_instr), 64'(NOP));
    chk("s1_valid_off", 64'(w1_valid), 64'(0));
    cyc();
    chk("s1_done_once", 64'(w1_done), 64'(0));
    wait_idle();

    // hold of two cycles per entry
    load(0, 32'hE5827002, 32'h10);
    load(1, 32'hE5927002, 32'h10);
    go(2, 0);
    for (int i = 0; i < 4; i++) begin
      chk("s2_instr", 64'(w2_instr), (i < 2) ? 64'h E5827002 : 64'hE5927002);
      chk("s2_data", 64'(w2_data), 64'h10);
      cyc();
    end
    chk("s2_done", 64'(w2_done), 64'(1));
    wait_idle();

    // looping program, stopped after ten entries
    load(2, 32'hE0823081, 32'h0);
    go(3, 1);
    for (int i = 0; i < 10; i++) begin
      chk("s3_step", 64'(w1_step), 64'(i % 3));
      chk("s3_no_done", 64'(w1_done), 64'(0));
      if (i == 9) stop = 1;
      cyc();
    end
    stop = 0;
    chk("s3_valid", 64'(w1_valid), 64'(0));
    chk("s3_issued", 64'(w1_issued), 64'(10));
    chk("s3_busy", 64'(w1_busy), 64'(0));
    chk("s3_done", 64'(w1_done), 64'(0));
    wait_idle();

    // zero length and over-length programs
    go(0, 0);
    chk("s4_done", 64'(w1_done), 64'(1));
    chk("s4_valid", 64'(w1_valid), 64'(0));
    wait_idle();
    go(17, 0);
    wait_idle();
    chk("s4_clamp1", 64'(w1_issued), 64'(16));
    chk("s4_clamp2", 64'(w2_issued), 64'(16));

    // reset mid-run together with a buffer write
    go(5, 1);
    cyc(); cyc();
    rst = 1; load_en = 1; load_addr = 4'd2; load_instr = 32'hAAAA5555; load_data = 32'h1234;
    cyc();
    rst = 0; load_en = 0;
    chk("s5_instr", 64'(w1_instr), 64'(NOP));
    chk("s5_valid", 64'(w1_valid), 64'(0));
    chk("s5_busy", 64'(w1_busy), 64'(0));
    chk("s5_issued", 64'(w1_issued), 64'(0));
    chk("s5_step", 64'(w1_step), 64'(0));
    go(3, 0);
    chk("s5_e0", 64'(w1_instr), 64'hE5827002);
    cyc(); cyc();
    chk("s5_e2", 64'(w1_instr), 64'hAAAA5555);
    chk("s5_d2", 64'(w1_data), 64'h1234);
    wait_idle();

    // stop on the last-entry boundary
    go(3, 0);
    cyc(); cyc();
    stop = 1;
    cyc();
    stop = 0;
    chk("s6_done", 64'(w1_done), 64'(0));
    chk("s6_issued", 64'(w1_issued), 64'(3));
    chk("s6_valid", 64'(w1_valid), 64'(0));
    cyc();
    chk("s6_done_late", 64'(w1_done), 64'(0));
    wait_idle();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom % 200) == 0;
      load_en    = ($urandom % 4) == 0;
      load_addr  = 4'($urandom);
      load_instr = $urandom;
      load_data  = $urandom;
      start      = ($urandom % 10) == 0;
      prog_len   = 5'($urandom_range(0, 18));
      loop_en    = ($urandom % 3) == 0;
      stop       = ($urandom % 25) == 0;
      cyc();
    end
    rst = 0; load_en = 0; start = 0; stop = 0;
    cyc(); cyc();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_stim_sequencer.md
Name: instr_stim_sequencer

Overview:
Programmable instruction/data stimulus engine that replaces hand-sequenced instruction driving in front of the processor core. It holds a loadable program of up to DEPTH instruction words, each paired with a memory read-data word. On start it issues entries one at a time, each held for HOLD_CYCLES clocks, with optional looping and abort. It sits between the bench/debug loader and the core's instruction and memdatain inputs.

Parameters:
WIDTH, 32, instruction and data word width
DEPTH, 16, program buffer entries; power of two, >= 2
HOLD_CYCLES, 1, clocks each entry is presented; >= 1
NOP_INSTR, 32'hE1A00000, word driven on instruction when not issuing (MOV r0,r0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
load_en  in  1  write one program entry this cycle
load_addr  in  AW=$clog2(DEPTH)  entry index
load_instr  in  WIDTH  instruction word to store
load_data  in  WIDTH  paired memdatain word to store
prog_len  in  AW+1  entries to issue, sampled on start
start  in  1  begin issuing from entry 0
loop_en  in  1  sampled on start; wrap to entry 0 after last
stop  in  1  abort issuing
instruction  out  WIDTH  current instruction to core
memdatain  out  WIDTH  current read data to core
valid  out  1  instruction/memdatain hold a program entry
busy  out  1  FSM in RUN
done  out  1  one-cycle pulse on normal completion
step_idx  out  AW  index of entry being presented
issued_count  out  16  entries issued since last start, saturating

Behaviour:
- Reset: FSM=IDLE; instruction=NOP_INSTR, memdatain=0, valid=0, busy=0, done=0, step_idx=0, issued_count=0, len/loop registers=0. Buffer contents are not reset.
- Buffer: two DEPTH x WIDTH arrays, synchronous write on load_en. load_en is accepted in every state. A write to the entry currently being presented does not change outputs until that entry is next fetched.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - prog_len=0: go to DONE; done pulses next cycle; valid stays 0.
  - prog_len>DEPTH: clamp length to DEPTH.
  - Otherwise latch len and loop, set step_idx=0 and issued_count=0, go to RUN.
  - Outputs show entry 0 with valid=1 from the cycle after start (1-cycle latency).
- RUN:
  - Hold counter counts HOLD_CYCLES clocks per entry.
  - On the last hold cycle, issued_count increments (saturates at 16'hFFFF).
  - If step_idx < len-1: advance step_idx.
  - Else if loop=1: wrap step_idx to 0.
  - Else: go to DONE.
  - Outputs are registered from buffer[step_idx] and change only at entry boundaries.
- DONE: one cycle. done=1, valid=0, instruction=NOP_INSTR, busy=0. Then go to IDLE. issued_count and step_idx hold their final values.
- stop=1 in RUN: next cycle go to IDLE, valid=0, instruction=NOP_INSTR, no done pulse, issued_count holds. Ignored in IDLE/DONE.
- start in RUN or DONE: ignored.
- Simultaneous start and stop in IDLE: start wins.
- Simultaneous stop and last-entry boundary: stop wins; the entry still counts as issued, no done pulse.
- rst mid-RUN: returns to reset values next edge regardless of other inputs.
- busy=1 exactly while in RUN.
- HOLD_CYCLES=1: a new entry every clock, no bubbles, including across loop wrap.

Test Plan:
- Load entries 0..4 = E3E00017, E0812000, E0823081, E3A0F000, EA000004 (data 0); start with prog_len=5, loop=0, HOLD=1 -> instruction sequence as loaded on 5 consecutive cycles starting 1 cycle after start; done pulses once; issued_count=5; then instruction=E1A00000, valid=0.
- Entry 0 = E5827002 / 00000010, entry 1 = E5927002 / 00000010; HOLD_CYCLES=2 -> each pair held exactly 2 cycles; memdatain=00000010 throughout; done pulses on cycle 5 after start.
- prog_len=3, loop=1, run 10 cycles, then stop -> step_idx pattern 0,1,2,0,1,2,...; no done pulse; issued_count=10; valid=0 one cycle after stop.
- prog_len=0 -> done pulses; valid never 1. prog_len=DEPTH+1 -> exactly DEPTH entries issued.
- rst asserted in the middle of RUN, simultaneous with load_en -> all outputs return to reset values; a following start replays the buffer (write landed, buffer not cleared).
- stop asserted on the last-entry boundary -> no done pulse; issued_count=len.
